// File: rtl/nios_ii_nios2_gen2_0_cpu_mul_seq.sv
// rtl/nios_ii_nios2_gen2_0_cpu_mul_seq.sv - two-pass 32x32 multiply sequencer for a 3-product 16x16 cell
//
// Purpose:
//   Drives an external 16x16 multiply cell twice per request. The cell provides
//   p1=al*bl, p2=al*bh and p3=ah*bl, each registered one clock after cell_en.
//   The sequencer folds them into a 64-bit product and returns the low word (MUL)
//   or the high word (MULXUU/MULXSS/MULXSU). The signed high words are obtained
//   from the unsigned product by subtracting the sign corrections.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   req_valid/ready/op/a/b   request handshake, opcode, operands
//   resp_valid/ready/data    response handshake and 32-bit result
//   cell_src1/src2/en        operands and clock enable to the multiply cell
//   cell_p1/p2/p3            registered products from the multiply cell

module nios_ii_nios2_gen2_0_cpu_mul_seq (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_data,
   output logic [31:0] cell_src1,
   output logic [31:0] cell_src2,
   output logic        cell_en,
   input  logic [31:0] cell_p1,
   input  logic [31:0] cell_p2,
   input  logic [31:0] cell_p3
);

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULXSS = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PASS1,
      S_PASS2,
      S_SUM,
      S_RESP
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [1:0]  op_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [63:0] acc_q;

   logic [32:0] cross_sum;
   logic [63:0] acc_d;
   logic [31:0] corr;
   logic [31:0] acc_hi;

   // Next-state and cell drive
   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      cell_en   = 1'b0;
      cell_src1 = 32'h0;
      cell_src2 = 32'h0;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_d = S_PASS1;
         end
         S_PASS1: begin
            cell_en   = 1'b1;
            cell_src1 = a_q;
            cell_src2 = b_q;
            state_d   = S_PASS2;
         end
         S_PASS2: begin
            // Second pass puts the high halves into the low lanes so p1 = ah*bh.
            cell_en   = 1'b1;
            cell_src1 = {16'h0, a_q[31:16]};
            cell_src2 = {16'h0, b_q[31:16]};
            state_d   = S_SUM;
         end
         S_SUM: begin
            state_d = S_RESP;
         end
         S_RESP: begin
            if (resp_ready) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Datapath: during PASS2 the cell shows pass-1 products, during SUM it shows ah*bh.
   always_comb begin
      cross_sum = {1'b0, cell_p2} + {1'b0, cell_p3};
      acc_d     = {32'h0, cell_p1} + ({31'h0, cross_sum} << 16);
      // Signed operand weights -2^31; subtracting the other operand from the
      // high word converts the unsigned product into the signed one.
      corr      = ((a_q[31] && op_q[1]) ? b_q : 32'h0)
                + ((b_q[31] && (op_q == OP_MULXSS)) ? a_q : 32'h0);
      acc_hi    = acc_q[63:32] + cell_p1 - corr;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         op_q       <= 2'b00;
         a_q        <= 32'h0;
         b_q        <= 32'h0;
         acc_q      <= 64'h0;
         resp_data  <= 32'h0;
         resp_valid <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  op_q <= req_op;
                  a_q  <= req_a;
                  b_q  <= req_b;
               end
            end
            S_PASS2: begin
               acc_q <= acc_d;
            end
            S_SUM: begin
               resp_data  <= (op_q == OP_MUL) ? acc_q[31:0] : acc_hi;
               resp_valid <= 1'b1;
            end
            S_RESP: begin
               if (resp_ready) resp_valid <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nios_ii_nios2_gen2_0_cpu_mul_seq.sv
// tb/tb_nios_ii_nios2_gen2_0_cpu_mul_seq.sv - scoreboard bench for the multiply sequencer

module tb_nios_ii_nios2_gen2_0_cpu_mul_seq;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic [31:0] cell_src1;
   logic [31:0] cell_src2;
   logic        cell_en;
   logic [31:0] cell_p1 = 32'h0;
   logic [31:0] cell_p2 = 32'h0;
   logic [31:0] cell_p3 = 32'h0;

   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_q[$];
   int          cell_en_cnt = 0;
   int          cell_en_exp = 0;
   int          rr_mode = 0;

   always #5 clk = ~clk;

   nios_ii_nios2_gen2_0_cpu_mul_seq dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .cell_src1  (cell_src1),
      .cell_src2  (cell_src2),
      .cell_en    (cell_en),
      .cell_p1    (cell_p1),
      .cell_p2    (cell_p2),
      .cell_p3    (cell_p3)
   );

   // Behavioural multiply cell: products registered one clock after cell_en.
   always @(posedge clk) begin
      if (cell_en) begin
         cell_p1 <= {16'h0, cell_src1[15:0]}  * {16'h0, cell_src2[15:0]};
         cell_p2 <= {16'h0, cell_src1[15:0]}  * {16'h0, cell_src2[31:16]};
         cell_p3 <= {16'h0, cell_src1[31:16]} * {16'h0, cell_src2[15:0]};
      end
   end

   function automatic logic [31:0] golden(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] xa;
      logic [63:0] xb;
      logic [63:0] p;
      xa = (op[1] && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
      xb = (op == 2'b10 && b[31]) ? {32'hFFFF_FFFF, b} : {32'h0, b};
      p  = xa * xb;
      return (op == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // resp_ready driver: 0 = always ready, 1 = random stalls, 2 = held low
   initial begin
      resp_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rr_mode)
            0:       resp_ready = 1'b1;
            1:       resp_ready = 1'($urandom_range(0, 1));
            default: resp_ready = 1'b0;
         endcase
      end
   end

   // Monitor: pops the scoreboard on each transfer, checks hold under stall.
   initial begin
      logic        held_v;
      logic [31:0] held_d;
      held_v = 1'b0;
      held_d = 32'h0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            held_v = 1'b0;
         end else begin
            if (cell_en) cell_en_cnt++;
            else check("cell_src_idle", cell_src1 | cell_src2, 32'h0);
            if (held_v) begin
               check("resp_hold_valid", {31'h0, resp_valid}, 32'h1);
               check("resp_hold_data", resp_data, held_d);
            end
            if (resp_valid && resp_ready) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL resp_unexpected: got %h want none", resp_data);
               end else begin
                  check("resp_data", resp_data, exp_q.pop_front());
               end
               held_v = 1'b0;
            end else if (resp_valid) begin
               held_v = 1'b1;
               held_d = resp_data;
            end else begin
               held_v = 1'b0;
            end
         end
      end
   end

   // Called just after a posedge; returns just after the acceptance edge.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int n;
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!req_ready && n < 200);
      if (!req_ready) begin
         check("req_timeout", {31'h0, req_ready}, 32'h1);
         req_valid = 1'b0;
      end else begin
         exp_q.push_back(golden(op, a, b));
         cell_en_exp += 2;
         @(posedge clk);
         #1;
         req_valid = 1'b0;
         req_op    = 2'($urandom);
         req_a     = $urandom;
         req_b     = $urandom;
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int n;
      reset_n   = 1'b0;
      req_valid = 1'b0;
      req_op    = 2'b00;
      req_a     = 32'h0;
      req_b     = 32'h0;
      #2;
      check("rst_req_ready", {31'h0, req_ready}, 32'h1);
      check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
      check("rst_resp_data", resp_data, 32'h0);
      check("rst_cell_en", {31'h0, cell_en}, 32'h0);
      check("rst_cell_src", cell_src1 | cell_src2, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: latency of a plain MUL
      rr_mode = 0;
      issue(2'b00, 32'd3, 32'd5);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         check($sformatf("lat_resp_valid_%0d", k), {31'h0, resp_valid}, {31'h0, k == 4});
         check($sformatf("lat_req_ready_%0d", k), {31'h0, req_ready}, {31'h0, k == 5});
      end
      @(posedge clk);
      #1;

      // 2/3: extreme and signed corners
      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue(2'b10, 32'h8000_0000, 32'h8000_0000);
      issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("const_mulxuu", golden(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
      check("const_mulxss", golden(2'b10, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
      check("const_mulxsu", golden(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);

      // 5: cell operand sequence
      issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
      @(negedge clk);
      check("pass1_en", {31'h0, cell_en}, 32'h1);
      check("pass1_src1", cell_src1, 32'h1234_5678);
      check("pass1_src2", cell_src2, 32'h9ABC_DEF0);
      @(negedge clk);
      check("pass2_en", {31'h0, cell_en}, 32'h1);
      check("pass2_src1", cell_src1, 32'h0000_1234);
      check("pass2_src2", cell_src2, 32'h0000_9ABC);
      @(negedge clk);
      check("sum_en", {31'h0, cell_en}, 32'h0);
      @(posedge clk);
      #1;

      // 4: backpressure with a dropped request pulse while busy
      rr_mode = 2;
      issue(2'b01, 32'hDEAD_BEEF, 32'h1234_5678);
      n = 0;
      while (!resp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("bp_wait_valid", {31'h0, resp_valid}, 32'h1);
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_op    = 2'b00;
      req_a     = 32'd9;
      req_b     = 32'd9;
      @(negedge clk);
      check("bp_req_ready", {31'h0, req_ready}, 32'h0);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("bp_still_valid", {31'h0, resp_valid}, 32'h1);
      rr_mode = 0;
      @(posedge clk);
      #1;
      issue(2'b11, 32'h8765_4321, 32'hFEDC_BA98);

      // 6: reset during PASS2 discards the operation
      issue(2'b10, $urandom, $urandom);
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      void'(exp_q.pop_back());
      cell_en_exp -= 1;
      #1;
      check("midrst_resp_valid", {31'h0, resp_valid}, 32'h0);
      check("midrst_cell_en", {31'h0, cell_en}, 32'h0);
      check("midrst_req_ready", {31'h0, req_ready}, 32'h1);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      issue(2'b00, 32'd7, 32'd6);
      check("const_mul76", golden(2'b00, 32'd7, 32'd6), 32'h0000_002A);

      // Random traffic with random response stalls
      rr_mode = 1;
      for (int i = 0; i < 3000; i++) begin
         issue(2'($urandom), pick(), pick());
      end

      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      rr_mode = 0;
      repeat (3) @(negedge clk);
      check("queue_drain", exp_q.size(), 32'h0);
      check("cell_en_cycles", cell_en_cnt, cell_en_exp);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
